mem_stage: RTL and testbench

- MEM pipeline stage of the LoongArch in-order core, between exe_stage and wb_stage.
- Collects data-SRAM responses (sram-like req/addr_ok/data_ok protocol) for loads and stores issued in EXE.
- Aligns and extends load data, and forms the 189-bit ms_to_ws_bus.
- Drives the ID bypass/stall bus; discards responses that belong to instructions flushed by a WB exception or ertn.

---
 rtl/mem_stage_pkg.sv | 32 +++
 rtl/mem_load_align.sv | 38 +++
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, load-op encodings and bus field positions for the MEM stage.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 194;
  localparam int MS_TO_WS_BUS_WD = 189;
  localparam int MS_TO_DS_BUS_WD = 39;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } ld_op_e;

  // es_to_ms / ms_to_ws field positions
  localparam int BUS_RES_LSB      = 32;
  localparam int BUS_RES_MSB      = 63;
  localparam int BUS_DEST_LSB     = 64;
  localparam int BUS_DEST_MSB     = 68;
  localparam int BUS_GR_WE        = 69;
  localparam int BUS_SYS          = 149;
  localparam int BUS_ERTN         = 150;
  localparam int BUS_EXC_A        = 151;
  localparam int BUS_EXC_LSB      = 184;
  localparam int BUS_EXC_MSB      = 187;
  localparam int BUS_RES_FROM_MEM = 189;
  localparam int BUS_LD_OP_LSB    = 190;
  localparam int BUS_LD_OP_MSB    = 192;
  localparam int BUS_MEM_REQ      = 193;

endpackage

// File: rtl/mem_load_align.sv
// Selects the byte/half lane of a load response and sign- or zero-extends it.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_ld_op,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr)
      2'b00: w_byte = i_rdata[7:0];
      2'b01: w_byte = i_rdata[15:8];
      2'b10: w_byte = i_rdata[23:16];
      2'b11: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Unlisted encodings fall back to a full-word load.
  always_comb begin
    o_result = i_rdata;
    case (i_ld_op)
      LD_B:    o_result = {{24{w_byte[7]}}, w_byte};
      LD_H:    o_result = {{16{w_half[15]}}, w_half};
      LD_BU:   o_result = {24'd0, w_byte};
      LD_HU:   o_result = {16'd0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: collects data-SRAM responses, aligns load data, drives WB
// payload and the ID bypass bus, and discards responses of flushed instructions.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       data_sram_req,
  input  logic                       data_sram_addr_ok,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ws_allowin,
  input  logic                       ws_block,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  output logic                       ms_ex
);

  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_payload;
  logic                       r_buf_valid;
  logic [31:0]                r_buf_data;
  logic [1:0]                 r_outst_cnt;
  logic [1:0]                 r_drop_cnt;

  logic        w_mem_req;
  logic        w_res_from_mem;
  logic [2:0]  w_ld_op;
  logic        w_data_live;
  logic        w_got_data;
  logic        w_ready_go;
  logic        w_handshake;
  logic        w_buf_capture;
  logic [1:0]  w_outst_next;
  logic [31:0] w_load_src;
  logic [31:0] w_load_result;
  logic [31:0] w_final_result;

  assign w_mem_req      = r_payload[BUS_MEM_REQ];
  assign w_res_from_mem = r_payload[BUS_RES_FROM_MEM];
  assign w_ld_op        = r_payload[BUS_LD_OP_MSB:BUS_LD_OP_LSB];

  // A response only belongs to the current instruction once all flushed ones are drained.
  assign w_data_live = data_sram_data_ok && (r_drop_cnt == 2'd0);
  assign w_got_data  = r_buf_valid || w_data_live;
  assign w_ready_go  = !w_mem_req || w_got_data;

  assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
  assign ms_to_ws_valid = r_ms_valid && w_ready_go;
  assign w_handshake    = ms_to_ws_valid && ws_allowin;

  assign w_buf_capture = r_ms_valid && w_mem_req && !r_buf_valid && w_data_live && !ws_allowin;

  always_comb begin
    w_outst_next = r_outst_cnt;
    if ((data_sram_req && data_sram_addr_ok) && !data_sram_data_ok) begin
      w_outst_next = r_outst_cnt + 2'd1;
    end else if (!(data_sram_req && data_sram_addr_ok) && data_sram_data_ok
                 && (r_outst_cnt != 2'd0)) begin
      w_outst_next = r_outst_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ms_valid  <= 1'b0;
      r_payload   <= '0;
      r_buf_valid <= 1'b0;
      r_buf_data  <= 32'd0;
      r_outst_cnt <= 2'd0;
      r_drop_cnt  <= 2'd0;
    end else begin
      if (ws_block) begin
        r_ms_valid <= 1'b0;
      end else if (ms_allowin) begin
        r_ms_valid <= es_to_ms_valid;
      end

      if (es_to_ms_valid && ms_allowin) begin
        r_payload <= es_to_ms_bus;
      end

      if (ws_block || w_handshake) begin
        r_buf_valid <= 1'b0;
      end else if (w_buf_capture) begin
        r_buf_valid <= 1'b1;
        r_buf_data  <= data_sram_rdata;
      end

      r_outst_cnt <= w_outst_next;

      // Everything still in flight after the flush cycle belongs to dead instructions.
      if (ws_block) begin
        r_drop_cnt <= w_outst_next;
      end else if (data_sram_data_ok && (r_drop_cnt != 2'd0)) begin
        r_drop_cnt <= r_drop_cnt - 2'd1;
      end
    end
  end

  assign w_load_src = r_buf_valid ? r_buf_data : data_sram_rdata;

  mem_load_align u_load_align (
    .i_rdata  (w_load_src),
    .i_addr   (r_payload[BUS_RES_LSB+1:BUS_RES_LSB]),
    .i_ld_op  (w_ld_op),
    .o_result (w_load_result)
  );

  assign w_final_result = w_res_from_mem ? w_load_result : r_payload[BUS_RES_MSB:BUS_RES_LSB];

  always_comb begin
    ms_to_ws_bus = r_payload[MS_TO_WS_BUS_WD-1:0];
    ms_to_ws_bus[BUS_RES_MSB:BUS_RES_LSB] = w_final_result;
  end

  assign ms_to_ds_bus = {r_ms_valid && r_payload[BUS_GR_WE],
                         r_payload[BUS_DEST_MSB:BUS_DEST_LSB],
                         w_final_result,
                         r_ms_valid && w_res_from_mem && !w_ready_go};

  assign ms_ex = r_ms_valid && ((|r_payload[BUS_EXC_MSB:BUS_EXC_LSB])
                                || r_payload[BUS_EXC_A]
                                || r_payload[BUS_ERTN]
                                || r_payload[BUS_SYS]);

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; WB-side payloads are checked against a scoreboard queue.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         es_to_ms_valid;
  logic [193:0] es_to_ms_bus;
  logic         ms_allowin;
  logic         data_sram_req;
  logic         data_sram_addr_ok;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;
  logic         ws_allowin;
  logic         ws_block;
  logic         ms_to_ws_valid;
  logic [188:0] ms_to_ws_bus;
  logic [38:0]  ms_to_ds_bus;
  logic         ms_ex;

  int n_checks = 0;
  int n_errors = 0;
  logic [188:0] sb[$];

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_allowin        (ms_allowin),
    .data_sram_req     (data_sram_req),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .ws_block          (ws_block),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_to_ds_bus      (ms_to_ds_bus),
    .ms_ex             (ms_ex)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input logic [1:0] a,
                                           input logic [2:0] op);
    logic [31:0] sb8;
    logic [31:0] sh16;
    sb8  = rdata >> {a, 3'b000};
    sh16 = rdata >> {a[1], 4'b0000};
    case (op)
      3'b001:  return {{24{sb8[7]}}, sb8[7:0]};
      3'b010:  return {{16{sh16[15]}}, sh16[15:0]};
      3'b011:  return {24'd0, sb8[7:0]};
      3'b100:  return {16'd0, sh16[15:0]};
      default: return rdata;
    endcase
  endfunction

  function automatic logic [193:0] mk_bus(input logic [31:0] alu, input logic [4:0] dest,
                                          input logic we, input logic mreq, input logic rfm,
                                          input logic [2:0] op);
    logic [193:0] b;
    b = '0;
    b[31:0]    = $urandom;
    b[63:32]   = alu;
    b[68:64]   = dest;
    b[69]      = we;
    b[101:70]  = $urandom;
    b[133:102] = $urandom;
    b[148:134] = 15'($urandom);
    b[183:152] = $urandom;
    b[188]     = 1'($urandom);
    b[189]     = rfm;
    b[192:190] = op;
    b[193]     = mreq;
    return b;
  endfunction

  function automatic logic [188:0] exp_ws(input logic [193:0] b, input logic [31:0] rdata);
    logic [188:0] e;
    e = b[188:0];
    if (b[189]) e[63:32] = ref_load(rdata, b[33:32], b[192:190]);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    data_sram_req     = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'hDEAD_DEAD;
    ws_allowin        = 1'b1;
    ws_block          = 1'b0;
  endtask

  task automatic issue(input logic [193:0] b, input logic handshake);
    es_to_ms_valid    = 1'b1;
    es_to_ms_bus      = b;
    data_sram_req     = handshake;
    data_sram_addr_ok = handshake;
  endtask

  // WB-side scoreboard: every MEM->WB handshake must match the oldest expected payload.
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_errors++;
        $error("FAIL sb_unexpected obs=%0h exp=none", ms_to_ws_bus);
      end
      if (sb.size() != 0) begin
        logic [188:0] e;
        e = sb.pop_front();
        assert (ms_to_ws_bus === e) else begin
          n_errors++;
          $error("FAIL sb_payload obs=%0h exp=%0h", ms_to_ws_bus, e);
        end
      end
    end
  end

  initial begin
    logic [193:0] b;
    logic [193:0] b2;
    reset             = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_to_ms_bus      = '0;
    data_sram_req     = 1'b0;
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = 32'd0;
    ws_allowin        = 1'b1;
    ws_block          = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("rst_allowin", 64'(ms_allowin), 64'd1);
    chk("rst_ex", 64'(ms_ex), 64'd0);
    chk("rst_ds_we_wait", 64'({ms_to_ds_bus[38], ms_to_ds_bus[0]}), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // LD.B from byte 3
    step();
    b = mk_bus(32'h1000_0003, 5'd3, 1'b1, 1'b1, 1'b1, 3'b001);
    issue(b, 1'b1);
    sb.push_back(exp_ws(b, 32'h8000_0000));
    @(negedge clk);
    chk("t1_allowin", 64'(ms_allowin), 64'd1);
    step();
    @(negedge clk);
    chk("t1_ld_wait", 64'(ms_to_ds_bus[0]), 64'd1);
    chk("t1_wait_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("t1_ds_we", 64'(ms_to_ds_bus[38]), 64'd1);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8000_0000;
    @(negedge clk);
    chk("t1_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("t1_ld_wait_low", 64'(ms_to_ds_bus[0]), 64'd0);
    chk("t1_ds_result", 64'(ms_to_ds_bus[32:1]), 64'hFFFF_FF80);

    // LD.HU buffered while WB stalls
    step();
    b = mk_bus(32'h2000_0002, 5'd4, 1'b1, 1'b1, 1'b1, 3'b100);
    issue(b, 1'b1);
    sb.push_back(exp_ws(b, 32'hBEEF_1234));
    @(negedge clk);
    step();
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBEEF_1234;
    @(negedge clk);
    chk("t2_valid_dok", 64'(ms_to_ws_valid), 64'd1);
    chk("t2_allowin_stall", 64'(ms_allowin), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      ws_allowin = 1'b0;
      @(negedge clk);
      chk("t2_buf_valid", 64'(ms_to_ws_valid), 64'd1);
      chk("t2_buf_result", 64'(ms_to_ws_bus[63:32]), 64'h0000_BEEF);
    end
    step();
    b = mk_bus(32'h3000_0000, 5'd6, 1'b1, 1'b1, 1'b1, 3'b000);
    issue(b, 1'b1);
    sb.push_back(exp_ws(b, 32'hCAFE_F00D));
    @(negedge clk);
    chk("t2_allowin_release", 64'(ms_allowin), 64'd1);
    step();
    @(negedge clk);
    chk("t2_buf_cleared", 64'(ms_to_ds_bus[0]), 64'd1);
    chk("t2_next_wait", 64'(ms_to_ws_valid), 64'd0);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hCAFE_F00D;
    @(negedge clk);
    chk("t2_next_valid", 64'(ms_to_ws_valid), 64'd1);

    // Flush with two responses outstanding
    step();
    b = mk_bus(32'h4000_0000, 5'd7, 1'b1, 1'b1, 1'b1, 3'b000);
    issue(b, 1'b1);
    @(negedge clk);
    step();
    b2 = mk_bus(32'h4000_0004, 5'd8, 1'b1, 1'b1, 1'b1, 3'b000);
    issue(b2, 1'b1);
    @(negedge clk);
    chk("t3_allowin_busy", 64'(ms_allowin), 64'd0);
    step();
    ws_block       = 1'b1;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = b2;
    @(negedge clk);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBAD0_0001;
    @(negedge clk);
    chk("t3_drop1_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("t3_drop1_allowin", 64'(ms_allowin), 64'd1);
    step();
    b = mk_bus(32'h5000_0000, 5'd9, 1'b1, 1'b1, 1'b1, 3'b000);
    issue(b, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBAD0_0002;
    sb.push_back(exp_ws(b, 32'h1111_2222));
    @(negedge clk);
    chk("t3_drop2_valid", 64'(ms_to_ws_valid), 64'd0);
    step();
    @(negedge clk);
    chk("t3_new_wait", 64'(ms_to_ds_bus[0]), 64'd1);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h1111_2222;
    @(negedge clk);
    chk("t3_new_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("t3_new_result", 64'(ms_to_ds_bus[32:1]), 64'h1111_2222);

    // Flush coincident with data_ok and a new addr_ok
    step();
    b = mk_bus(32'h6000_0001, 5'd10, 1'b1, 1'b1, 1'b1, 3'b001);
    issue(b, 1'b1);
    @(negedge clk);
    step();
    b2 = mk_bus(32'h6000_0008, 5'd11, 1'b1, 1'b1, 1'b1, 3'b000);
    issue(b2, 1'b1);
    ws_block          = 1'b1;
    ws_allowin        = 1'b0;
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_7700;
    @(negedge clk);
    step();
    b = mk_bus(32'h7000_0002, 5'd12, 1'b1, 1'b1, 1'b1, 3'b010);
    issue(b, 1'b1);
    sb.push_back(exp_ws(b, 32'h8001_0000));
    @(negedge clk);
    chk("t4_empty_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("t4_empty_we", 64'(ms_to_ds_bus[38]), 64'd0);
    chk("t4_empty_allowin", 64'(ms_allowin), 64'd1);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hBAD0_0003;
    @(negedge clk);
    chk("t4_drop_wait", 64'(ms_to_ds_bus[0]), 64'd1);
    chk("t4_drop_valid", 64'(ms_to_ws_valid), 64'd0);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h8001_0000;
    @(negedge clk);
    chk("t4_new_result", 64'(ms_to_ds_bus[32:1]), 64'hFFFF_8001);

    // ALU op and a store
    step();
    b = mk_bus(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
    issue(b, 1'b0);
    sb.push_back(exp_ws(b, 32'h0));
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t5_valid", 64'(ms_to_ws_valid), 64'd1);
    chk("t5_ds_bus", 64'(ms_to_ds_bus), 64'({1'b1, 5'd5, 32'h0000_1234, 1'b0}));
    step();
    b = mk_bus(32'h9000_0004, 5'd0, 1'b0, 1'b1, 1'b0, 3'b000);
    issue(b, 1'b1);
    sb.push_back(exp_ws(b, 32'hFFFF_FFFF));
    @(negedge clk);
    step();
    @(negedge clk);
    chk("t5_st_wait_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("t5_st_no_ld_wait", 64'(ms_to_ds_bus[0]), 64'd0);
    step();
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("t5_st_result", 64'(ms_to_ws_bus[63:32]), 64'h9000_0004);

    // Exception and ertn
    step();
    b = mk_bus(32'h0000_00AA, 5'd1, 1'b0, 1'b0, 1'b0, 3'b000);
    b[149] = 1'b1;
    issue(b, 1'b0);
    sb.push_back(exp_ws(b, 32'h0));
    @(negedge clk);
    chk("t6_ex_before", 64'(ms_ex), 64'd0);
    step();
    ws_allowin = 1'b0;
    @(negedge clk);
    chk("t6_ex_stall", 64'(ms_ex), 64'd1);
    chk("t6_sys_bit", 64'(ms_to_ws_bus[149]), 64'd1);
    step();
    b = mk_bus(32'h0000_00BB, 5'd2, 1'b0, 1'b0, 1'b0, 3'b000);
    b[150] = 1'b1;
    issue(b, 1'b0);
    sb.push_back(exp_ws(b, 32'h0));
    @(negedge clk);
    chk("t6_ex_hs", 64'(ms_ex), 64'd1);
    step();
    @(negedge clk);
    chk("t6_ertn", 64'(ms_ex), 64'd1);
    step();
    @(negedge clk);
    chk("t6_ex_clear", 64'(ms_ex), 64'd0);

    // Asynchronous reset while an instruction is held
    step();
    b = mk_bus(32'h0000_0055, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
    issue(b, 1'b0);
    ws_allowin = 1'b0;
    @(negedge clk);
    step();
    ws_allowin = 1'b0;
    @(negedge clk);
    chk("t7_held", 64'(ms_to_ws_valid), 64'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("t7_async_valid", 64'(ms_to_ws_valid), 64'd0);
    chk("t7_async_we", 64'(ms_to_ds_bus[38]), 64'd0);
    #1;
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("t7_after_valid", 64'(ms_to_ws_valid), 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
